// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB-first through two halfadders and a registered carry.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [CW-1:0] cnt;
  logic carry, h1s, h1c, bit_s, h2c, carry_nx, last;
  halfadder u_ha1 (.a(sa[0]), .b(sb[0]), .s(h1s), .c(h1c));
  halfadder u_ha2 (.a(h1s), .b(carry), .s(bit_s), .c(h2c));
  assign carry_nx = h1c | h2c;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE && start) begin
      sa    <= a;
      sb    <= b;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == SHIFT) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= carry_nx;
      acc   <= {bit_s, acc[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {bit_s, acc[WIDTH-1:1]};
        cout <= carry_nx;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench; expected {cout,sum} queued at start, compared on done.
module tb_serial_adder_ctrl;
  logic clk = 0, rst = 1, start = 0, busy, done, cout;
  logic [7:0] a = 0, b = 0, sum;
  logic [8:0] sb_q[$];
  int n_chk = 0, n_pass = 0, done_cnt = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb_q.size() == 0) chk("spurious_done", 1, 0);
      else chk("result", {23'd0, cout, sum}, {23'd0, sb_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y);
    int n = 0, bc = 0;
    a = x; b = y; start = 1;
    sb_q.push_back({1'b0, x} + {1'b0, y});
    tick();
    start = 0;
    while (!done && n < 40) begin
      bc += int'(busy);
      tick();
      n++;
    end
    chk("latency", n, 8);
    chk("busy_cycles", bc, 8);
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
  endtask

  initial begin
    int n, d0;
    tick(); tick();
    rst = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", {24'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    tick();
    op(8'h00, 8'h00);
    op(8'h5A, 8'h3C);
    op(8'hFF, 8'h01);
    op(8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold", {23'd0, cout, sum}, 9'h1FE);
    end
    d0 = done_cnt;
    sb_q.push_back(9'h010);
    a = 8'h0F; b = 8'h01; start = 1;
    tick();
    start = 0;
    tick(); tick();
    a = 8'hAA; b = 8'h55; start = 1;
    tick();
    start = 0;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("ign_done_seen", {31'd0, done}, 1);
    start = 1;
    tick();
    start = 0;
    chk("ign_done_low", {31'd0, done}, 0);
    chk("ign_busy_low", {31'd0, busy}, 0);
    repeat (12) tick();
    chk("ign_one_pulse", done_cnt - d0, 1);
    chk("ign_sum", {23'd0, cout, sum}, 9'h010);
    d0 = done_cnt;
    a = 8'h80; b = 8'h80; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    chk("mid_busy", {31'd0, busy}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_sum", {23'd0, cout, sum}, 0);
    repeat (12) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    op(8'h80, 8'h80);
    op(8'h01, 8'h02);
    for (int i = 0; i < 200; i++) op(8'($urandom), 8'($urandom));
    tick();
    chk("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
